// File: rtl/text_console_writer_pkg.sv
// Shared display definitions: geometry defaults, control codes, ctrl_reg layout
// and the logical-to-physical row mapping used by both writer and display side.
package text_console_writer_pkg;

  localparam int COLS_DEFAULT = 80;
  localparam int ROWS_DEFAULT = 30;
  localparam int X_W_DEFAULT  = 8;
  localparam int Y_W_DEFAULT  = 5;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  localparam int CTRL_X_LSB   = 0;
  localparam int CTRL_Y_LSB   = 8;
  localparam int CTRL_BG_LSB  = 16;
  localparam int CTRL_FG_LSB  = 20;
  localparam int CTRL_SCR_LSB = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ALL = 2'd1,
    CLR_ROW = 2'd2
  } wr_state_e;

  // Scroll is always < rows, so one conditional subtract implements the modulo.
  function automatic logic [7:0] phys_row(input logic [7:0] log_y,
                                          input logic [7:0] scroll,
                                          input logic [7:0] rows);
    logic [8:0] sum;
    sum = {1'b0, log_y} + {1'b0, scroll};
    if (sum >= {1'b0, rows}) sum = sum - {1'b0, rows};
    return sum[7:0];
  endfunction

  function automatic logic [31:0] pack_ctrl(input logic [7:0] x,
                                            input logic [4:0] y,
                                            input logic [3:0] bg,
                                            input logic [3:0] fg,
                                            input logic [4:0] scroll);
    logic [31:0] r;
    r = '0;
    r[CTRL_X_LSB +: 8]   = x;
    r[CTRL_Y_LSB +: 5]   = y;
    r[CTRL_BG_LSB +: 4]  = bg;
    r[CTRL_FG_LSB +: 4]  = fg;
    r[CTRL_SCR_LSB +: 5] = scroll;
    return r;
  endfunction

endpackage

// File: rtl/text_console_writer.sv
// Character-stream writer for a scrolling text console: interprets control codes,
// tracks cursor and scroll, and clears rows/screen one cell per cycle.
module text_console_writer
  import text_console_writer_pkg::*;
#(
  parameter int COLS = COLS_DEFAULT,
  parameter int ROWS = ROWS_DEFAULT,
  parameter int X_W  = X_W_DEFAULT,
  parameter int Y_W  = Y_W_DEFAULT
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  input  logic [7:0]     in_char,
  output logic           in_ready,
  input  logic           color_we,
  input  logic [7:0]     color_in,
  output logic           buf_we,
  output logic [X_W-1:0] buf_x,
  output logic [Y_W-1:0] buf_y,
  output logic [7:0]     buf_data,
  output logic [31:0]    ctrl_reg
);

  localparam logic [X_W-1:0] X_LAST  = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(ROWS - 1);
  localparam logic [X_W:0]   COLS_EXT = (X_W + 1)'(COLS);

  wr_state_e      state_q, state_d;
  logic [X_W-1:0] cx_q, cx_d;
  logic [Y_W-1:0] cy_q, cy_d;
  logic [Y_W-1:0] scr_q, scr_d;
  logic [3:0]     fg_q, fg_d;
  logic [3:0]     bg_q, bg_d;
  logic [X_W-1:0] clx_q, clx_d;
  logic [Y_W-1:0] cly_q, cly_d;
  logic           we_q, we_d;
  logic [X_W-1:0] bx_q, bx_d;
  logic [Y_W-1:0] by_q, by_d;
  logic [7:0]     bd_q, bd_d;
  logic [31:0]    ctrl_q, ctrl_d;

  logic           accept;
  logic           lf;
  logic [X_W:0]   tab_nx;
  logic [Y_W-1:0] cur_phys;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    scr_d    = scr_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    clx_d    = clx_q;
    cly_d    = cly_q;
    we_d     = 1'b0;
    bx_d     = bx_q;
    by_d     = by_q;
    bd_d     = bd_q;
    lf       = 1'b0;
    tab_nx   = {1'b0, cx_q | X_W'(7)} + (X_W + 1)'(1);
    cur_phys = Y_W'(phys_row(8'(cy_q), 8'(scr_q), 8'(ROWS)));

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_char >= CH_SPACE && in_char <= CH_TILDE) begin
            we_d = 1'b1;
            bx_d = cx_q;
            by_d = cur_phys;
            bd_d = in_char;
            if (cx_q == X_LAST) begin
              cx_d = '0;
              lf   = 1'b1;
            end else begin
              cx_d = cx_q + X_W'(1);
            end
          end else begin
            case (in_char)
              CH_LF: begin
                cx_d = '0;
                lf   = 1'b1;
              end
              CH_CR: cx_d = '0;
              CH_BS: begin
                if (cx_q != '0) begin
                  cx_d = cx_q - X_W'(1);
                  we_d = 1'b1;
                  bx_d = cx_q - X_W'(1);
                  by_d = cur_phys;
                  bd_d = CH_SPACE;
                end
              end
              CH_TAB: begin
                if (tab_nx >= COLS_EXT) begin
                  cx_d = '0;
                  lf   = 1'b1;
                end else begin
                  cx_d = tab_nx[X_W-1:0];
                end
              end
              CH_FF: begin
                cx_d    = '0;
                cy_d    = '0;
                scr_d   = '0;
                clx_d   = '0;
                cly_d   = '0;
                state_d = CLR_ALL;
              end
              default: ;
            endcase
          end

          // The row leaving the top of the window becomes the new bottom row.
          if (lf) begin
            if (cy_q != Y_LAST) begin
              cy_d = cy_q + Y_W'(1);
            end else begin
              scr_d   = (scr_q == Y_LAST) ? '0 : scr_q + Y_W'(1);
              clx_d   = '0;
              cly_d   = scr_q;
              state_d = CLR_ROW;
            end
          end
        end
      end

      CLR_ALL: begin
        we_d = 1'b1;
        bx_d = clx_q;
        by_d = cly_q;
        bd_d = CH_SPACE;
        if (clx_q == X_LAST) begin
          clx_d = '0;
          if (cly_q == Y_LAST) begin
            cly_d   = '0;
            state_d = IDLE;
          end else begin
            cly_d = cly_q + Y_W'(1);
          end
        end else begin
          clx_d = clx_q + X_W'(1);
        end
      end

      CLR_ROW: begin
        we_d = 1'b1;
        bx_d = clx_q;
        by_d = cly_q;
        bd_d = CH_SPACE;
        if (clx_q == X_LAST) begin
          clx_d   = '0;
          state_d = IDLE;
        end else begin
          clx_d = clx_q + X_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    if (color_we) begin
      fg_d = color_in[7:4];
      bg_d = color_in[3:0];
    end

    ctrl_d = pack_ctrl(8'(cx_d), 5'(cy_d), bg_d, fg_d, 5'(scr_d));
  end

  // Register stage: all state and every output update together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= CLR_ALL;
      cx_q    <= '0;
      cy_q    <= '0;
      scr_q   <= '0;
      fg_q    <= 4'hF;
      bg_q    <= 4'h0;
      clx_q   <= '0;
      cly_q   <= '0;
      we_q    <= 1'b0;
      bx_q    <= '0;
      by_q    <= '0;
      bd_q    <= '0;
      ctrl_q  <= pack_ctrl(8'h00, 5'h00, 4'h0, 4'hF, 5'h00);
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      scr_q   <= scr_d;
      fg_q    <= fg_d;
      bg_q    <= bg_d;
      clx_q   <= clx_d;
      cly_q   <= cly_d;
      we_q    <= we_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      bd_q    <= bd_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign buf_we   = we_q;
  assign buf_x    = bx_q;
  assign buf_y    = by_q;
  assign buf_data = bd_q;
  assign ctrl_reg = ctrl_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: stimulus queues expected buffer writes,
// a negedge monitor pops and compares every write the DUT presents.
module tb_text_console_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_ready;
  logic        color_we;
  logic [7:0]  color_in;
  logic        buf_we;
  logic [7:0]  buf_x;
  logic [4:0]  buf_y;
  logic [7:0]  buf_data;
  logic [31:0] ctrl_reg;

  always #5 clk = ~clk;

  text_console_writer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_char  (in_char),
    .in_ready (in_ready),
    .color_we (color_we),
    .color_in (color_in),
    .buf_we   (buf_we),
    .buf_x    (buf_x),
    .buf_y    (buf_y),
    .buf_data (buf_data),
    .ctrl_reg (ctrl_reg)
  );

  typedef struct {
    int x;
    int y;
    int d;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   cyc   = 0;
  int   nwr   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: every presented write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (buf_we === 1'b1) begin
      exp_t e;
      nwr++;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual=(%0d,%0d,%h) required=none", buf_x, buf_y, buf_data);
      end else begin
        e = sbq.pop_front();
        chk("write", {8'h00, buf_x, 3'b000, buf_y, buf_data},
            {8'h00, 8'(e.x), 3'b000, 5'(e.y), 8'(e.d)});
        if (e.cyc >= 0) chk("write_latency", cyc, e.cyc);
      end
    end
  end

  task automatic push(input int x, input int y, input int d, input int c);
    exp_t e;
    e.x = x; e.y = y; e.d = d; e.cyc = c;
    sbq.push_back(e);
  endtask

  task automatic push_clear_all();
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 80; x++)
        push(x, y, 32'h20, -1);
  endtask

  task automatic send(input logic [7:0] c, input bit expw,
                      input int ex, input int ey, input int ed);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = c;
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=ready_low required=ready_high");
    end
    if (expw) push(ex, ey, ed, cyc + 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=ready_low required=ready_high", nm);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_char  = 8'h00;
    color_we = 1'b0;
    color_in = 8'h00;

    // Reset state and full-screen clear on release
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_buf_we", 32'(buf_we), 32'd0);
    chk("rst_buf_addr", {8'h00, buf_x, 3'b000, buf_y, buf_data}, 32'h0);
    chk("rst_ctrl", ctrl_reg, 32'h00F00000);
    push_clear_all();
    base = nwr;
    reset_n = 1'b1;
    wait_ready("reset_clear");
    repeat (2) @(negedge clk);
    chk("reset_clear_count", nwr - base, 2400);
    chk("reset_clear_queue", sbq.size(), 0);
    chk("reset_clear_ctrl", ctrl_reg, 32'h00F00000);

    // Plain writes
    send(8'h41, 1'b1, 0, 0, 8'h41);
    send(8'h42, 1'b1, 1, 0, 8'h42);
    @(negedge clk);
    chk("ab_ctrl", ctrl_reg, 32'h00F00002);

    // Wrap across a full row
    send(8'h0D, 1'b0, 0, 0, 0);
    for (int i = 0; i < 80; i++) send(8'h41, 1'b1, i, 0, 8'h41);
    @(negedge clk);
    chk("wrap_ready", 32'(in_ready), 32'd1);
    chk("wrap_ctrl", ctrl_reg, 32'h00F00100);
    repeat (3) @(negedge clk);
    chk("wrap_queue", sbq.size(), 0);

    // Form feed, then backspace and tab
    push_clear_all();
    send(8'h0C, 1'b0, 0, 0, 0);
    wait_ready("ff_clear");
    repeat (2) @(negedge clk);
    chk("ff_queue", sbq.size(), 0);
    chk("ff_ctrl", ctrl_reg, 32'h00F00000);
    send(8'h61, 1'b1, 0, 0, 8'h61);
    send(8'h62, 1'b1, 1, 0, 8'h62);
    send(8'h08, 1'b1, 1, 0, 8'h20);
    @(negedge clk);
    chk("bs_ctrl", ctrl_reg, 32'h00F00001);
    send(8'h09, 1'b0, 0, 0, 0);
    @(negedge clk);
    chk("tab_ctrl", ctrl_reg, 32'h00F00008);
    send(8'h0D, 1'b0, 0, 0, 0);
    send(8'h08, 1'b0, 0, 0, 0);
    send(8'h01, 1'b0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("bs_x0_ctrl", ctrl_reg, 32'h00F00000);
    chk("bs_x0_queue", sbq.size(), 0);

    // Color register
    color_we = 1'b1;
    color_in = 8'hA5;
    @(negedge clk);
    color_we = 1'b0;
    chk("color_ctrl", ctrl_reg, 32'h00A50000);

    // Scroll at the bottom row
    for (int i = 0; i < 29; i++) send(8'h0A, 1'b0, 0, 0, 0);
    @(negedge clk);
    chk("bottom_ctrl", ctrl_reg, 32'h00A51D00);
    for (int x = 0; x < 80; x++) push(x, 0, 32'h20, -1);
    send(8'h0A, 1'b0, 0, 0, 0);
    n = 0;
    while (!in_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    chk("scroll_busy_cycles", n, 80);
    @(negedge clk);
    chk("scroll_queue", sbq.size(), 0);
    chk("scroll_ctrl", ctrl_reg, 32'h01A51D00);
    send(8'h41, 1'b1, 0, 0, 8'h41);
    @(negedge clk);
    chk("post_scroll_ctrl", ctrl_reg, 32'h01A51D01);

    // Reset in the middle of a full clear
    push_clear_all();
    base = nwr;
    send(8'h0C, 1'b0, 0, 0, 0);
    n = 0;
    while ((nwr - base) < 500 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("midclear_reached", 32'((nwr - base) >= 500), 32'd1);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    sbq.delete();
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_buf_we", 32'(buf_we), 32'd0);
    chk("midrst_ctrl", ctrl_reg, 32'h00F00000);
    push_clear_all();
    base = nwr;
    reset_n = 1'b1;
    wait_ready("midrst_clear");
    repeat (2) @(negedge clk);
    chk("midrst_clear_count", nwr - base, 2400);
    chk("midrst_queue", sbq.size(), 0);
    chk("midrst_final_ctrl", ctrl_reg, 32'h00F00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
